btn_rst_req: RTL and testbench

BTN_RST_REQ -- requirements
Module: btn_rst_req

---
 rtl/rst_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 40 ++++
 rtl/btn_rst_req.sv | 170 +++++++++++++++++
 tb/tb_btn_rst_req.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_pkg.sv
// ---------------------------------------------------------------------------
// rst_pkg -- shared types and constants for the reset-request path.
//
// Holds the button reset-request FSM state type, plus the constants that the
// downstream reset generator (the block driven by btn_rst_req.rst_req_o) is
// built around, so both ends of the path agree on them.
// ---------------------------------------------------------------------------
package rst_pkg;

   // Button reset-request FSM states.
   typedef enum logic [2:0] {
      IDLE       = 3'd0,   // released, waiting for a press
      PRESS_DB   = 3'd1,   // press seen, confirming it is stable
      PULSE      = 3'd2,   // issuing the reset request pulse
      HELD       = 3'd3,   // accepted press, still held down
      RELEASE_DB = 3'd4    // release seen, confirming it is stable
   } btn_state_e;

   // Downstream reset generator constants.
   localparam int unsigned RSTGEN_SYNC_STAGES = 2;     // reset deassert sync depth
   localparam int unsigned RSTGEN_HOLD_CYCLES = 8;     // min reset assertion width
   localparam logic        RSTGEN_REQ_ACTIVE  = 1'b1;  // request input polarity

   // States in which the debounced button level reads as pressed.
   function automatic logic state_is_pressed(btn_state_e s);
      return (s == PULSE) || (s == HELD) || (s == RELEASE_DB);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff -- two-flop synchronizer for a single asynchronous bit.
//
// Ports
//   clk_i  : destination clock (rising edge)
//   rst_i  : synchronous active-high reset, loads RESET_VAL into both flops
//   d_i    : asynchronous input
//   q_o    : synchronized output (two clk_i edges of latency)
//
// RESET_VAL lets the caller pick the idle level of the input so that a reset
// does not look like an input transition downstream.
// ---------------------------------------------------------------------------
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   // Bit 0 is the metastability-catching stage, bit 1 is the clean output.
   always_comb begin
      sync_d = {sync_q[0], d_i};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {2{RESET_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/btn_rst_req.sv
// ---------------------------------------------------------------------------
// btn_rst_req -- debounced push-button to reset-request pulse.
//
// A raw, bouncing, active-low button is synchronized, debounced in both
// directions, and turned into exactly one PULSE_CYCLES-wide request pulse per
// accepted press. Holding the button does not repeat the request; a new
// request needs a debounced release followed by a new debounced press.
//
// Parameters
//   DEBOUNCE_CYCLES : stable synchronized samples needed to accept a press or
//                     a release (2..65535)
//   PULSE_CYCLES    : width of the request pulse in clk_i cycles (1..255)
//
// Ports
//   clk_i     : system clock, rising edge
//   rst_i     : synchronous active-high reset
//   btn_ni    : raw button, active-low, asynchronous, bouncing
//   rst_req_o : registered reset request pulse, active-high
//   pressed_o : registered debounced button level, 1 = pressed
//
// Timing: a press first sampled at edge k enters PRESS_DB at k+2 and raises
// rst_req_o at k+2+DEBOUNCE_CYCLES.
// ---------------------------------------------------------------------------
module btn_rst_req
   import rst_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned PULSE_CYCLES    = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_ni,
   output logic rst_req_o,
   output logic pressed_o
);

   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned PCNT_W = $clog2(PULSE_CYCLES + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_CYCLES - 1);

   // ------------------------------------------------------------------------
   // Input synchronizer. Flops idle at 1 (released) so leaving reset never
   // looks like a press edge; a button still held through reset shows up two
   // edges later and is debounced afresh.
   // ------------------------------------------------------------------------
   logic btn_sync;
   logic btn_s;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (btn_ni),
      .q_o   (btn_sync)
   );

   assign btn_s = ~btn_sync;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   btn_state_e        state_q,   state_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic [PCNT_W-1:0] pcnt_q,    pcnt_d;
   logic              rst_req_q, rst_req_d;
   logic              pressed_q, pressed_d;

   // ------------------------------------------------------------------------
   // Next-state logic. cnt is cleared on every state entry so the debounce
   // windows always start from zero and can never wrap. PRESS_DB/RELEASE_DB
   // leave on the sample where cnt reaches DEBOUNCE_CYCLES-1, i.e. after
   // exactly DEBOUNCE_CYCLES cycles in the state.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pcnt_d  = pcnt_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (btn_s) begin
               state_d = PRESS_DB;
            end
         end

         PRESS_DB: begin
            if (!btn_s) begin
               // Bounce: drop the partial press.
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PULSE;
               cnt_d   = '0;
               pcnt_d  = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         PULSE: begin
            // The button is ignored here: a release during the pulse must not
            // shorten it. It is picked up from HELD on the following cycle.
            // pcnt stays at its last value on exit (saturates, no wrap).
            if (pcnt_q == PCNT_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end

         HELD: begin
            cnt_d = '0;
            if (!btn_s) begin
               state_d = RELEASE_DB;
            end
         end

         RELEASE_DB: begin
            if (btn_s) begin
               // Bounce back to pressed: keep the press, no new request.
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            pcnt_d  = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up exactly with
   // the state occupancy while staying flop-driven.
   always_comb begin
      rst_req_d = (state_d == PULSE);
      pressed_d = state_is_pressed(state_d);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pcnt_q    <= '0;
         rst_req_q <= 1'b0;
         pressed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pcnt_q    <= pcnt_d;
         rst_req_q <= rst_req_d;
         pressed_q <= pressed_d;
      end
   end

   assign rst_req_o = rst_req_q;
   assign pressed_o = pressed_q;

endmodule

// File: tb/tb_btn_rst_req.sv
module tb_btn_rst_req;
   import rst_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1, btn1, rst2, btn2;
   logic req1, prs1, req2, prs2;

   btn_rst_req #(.DEBOUNCE_CYCLES(16), .PULSE_CYCLES(4)) dut (
      .clk_i(clk), .rst_i(rst1), .btn_ni(btn1), .rst_req_o(req1), .pressed_o(prs1));

   btn_rst_req #(.DEBOUNCE_CYCLES(2), .PULSE_CYCLES(1)) dut2 (
      .clk_i(clk), .rst_i(rst2), .btn_ni(btn2), .rst_req_o(req2), .pressed_o(prs2));

   int n_cmp  = 0;
   int n_fail = 0;
   int edge_n = 0;
   bit chk_on = 0;

   // ---------------- reference model (run-length view) -----------------
   // mode 0: released, counting consecutive pressed samples
   // mode 1: pulsing, rem = pulse cycles still to come
   // mode 2: pressed, counting consecutive released samples
   int m_d[2] = '{16, 2};
   int m_p[2] = '{4, 1};
   int m_mode[2], m_run[2], m_rem[2];
   bit m_h1[2], m_h2[2];
   bit m_req[2], m_prs[2];

   task automatic model_step(int i, bit rst, bit raw);
      bit s;
      if (rst) begin
         m_mode[i] = 0; m_run[i] = 0; m_rem[i] = 0;
         m_h1[i] = 1'b1; m_h2[i] = 1'b1;
         m_req[i] = 1'b0; m_prs[i] = 1'b0;
         return;
      end
      s = !m_h2[i];               // raw level seen two edges ago, inverted
      m_h2[i] = m_h1[i];
      m_h1[i] = raw;
      case (m_mode[i])
         0: begin
            m_run[i] = s ? m_run[i] + 1 : 0;
            if (m_run[i] == m_d[i] + 1) begin
               m_mode[i] = 1; m_rem[i] = m_p[i] - 1; m_run[i] = 0;
            end
         end
         1: begin
            if (m_rem[i] == 0) begin m_mode[i] = 2; m_run[i] = 0; end
            else m_rem[i]--;
         end
         default: begin
            m_run[i] = !s ? m_run[i] + 1 : 0;
            if (m_run[i] == m_d[i] + 1) begin m_mode[i] = 0; m_run[i] = 0; end
         end
      endcase
      m_req[i] = (m_mode[i] == 1);
      m_prs[i] = (m_mode[i] != 0);
   endtask

   task automatic check(string name, logic act, logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s edge=%0d actual=%b required=%b", name, edge_n, act, exp);
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s edge=%0d actual=%0d required=%0d", name, edge_n, act, exp);
      end
   endtask

   // ---------------- edge tracking -----------------
   logic req1_p = 0, prs1_p = 0, req2_p = 0;
   int rise1 = -1, fall1 = -1, prise1 = -1, pfall1 = -1, pulses1 = 0;
   int rise2 = -1, fall2 = -1, pulses2 = 0;

   task automatic tick();
      @(posedge clk);
      edge_n++;
      model_step(0, rst1, btn1);
      model_step(1, rst2, btn2);
      #1;
      chk_on = 1;
      check("model_req1", req1, m_req[0]);
      check("model_prs1", prs1, m_prs[0]);
      check("model_req2", req2, m_req[1]);
      check("model_prs2", prs2, m_prs[1]);
      if (req1 && !req1_p) begin rise1 = edge_n; pulses1++; end
      if (!req1 && req1_p) fall1 = edge_n;
      if (prs1 && !prs1_p) prise1 = edge_n;
      if (!prs1 && prs1_p) pfall1 = edge_n;
      if (req2 && !req2_p) begin rise2 = edge_n; pulses2++; end
      if (!req2 && req2_p) fall2 = edge_n;
      req1_p = req1; prs1_p = prs1; req2_p = req2;
   endtask

   // ---------------- structural assertions -----------------
   always @(negedge clk) begin
      if (chk_on) begin
         n_cmp += 4;
         assert (!req1 || dut.state_q == PULSE) else begin
            n_fail++; $display("FAIL req1_outside_pulse edge=%0d state=%0d", edge_n, dut.state_q);
         end
         assert (!req2 || dut2.state_q == PULSE) else begin
            n_fail++; $display("FAIL req2_outside_pulse edge=%0d state=%0d", edge_n, dut2.state_q);
         end
         assert (int'(dut.cnt_q) <= 15) else begin
            n_fail++; $display("FAIL cnt1_range edge=%0d actual=%0d required<=15", edge_n, dut.cnt_q);
         end
         assert (int'(dut2.cnt_q) <= 1) else begin
            n_fail++; $display("FAIL cnt2_range edge=%0d actual=%0d required<=1", edge_n, dut2.cnt_q);
         end
      end
   end

   // ---------------- vector table -----------------
   typedef struct {
      bit rst;
      bit btn;
      int cyc;
      bit exp_req;
      bit exp_prs;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int k, r, t, b, f, p0, seg1, seg2;

      tbl[0]  = '{1, 1,  3, 0, 0};   // reset state
      tbl[1]  = '{0, 1,  5, 0, 0};   // idle released
      tbl[2]  = '{0, 0, 17, 0, 0};   // still debouncing at k+16
      tbl[3]  = '{0, 0,  2, 1, 1};   // pulse starts k+18
      tbl[4]  = '{0, 0,  3, 1, 1};   // last pulse cycle k+21
      tbl[5]  = '{0, 0,  1, 0, 1};   // pulse ended, held
      tbl[6]  = '{0, 1,  5, 0, 1};   // short release rejected
      tbl[7]  = '{0, 0, 10, 0, 1};   // held, no new pulse
      tbl[8]  = '{0, 1, 17, 0, 1};   // release debouncing r+16
      tbl[9]  = '{0, 1,  1, 0, 1};   // r+17 still pressed
      tbl[10] = '{0, 1,  1, 0, 0};   // r+18 released
      tbl[11] = '{0, 0, 20, 1, 1};   // new press, mid-pulse at k+19
      tbl[12] = '{1, 0,  1, 0, 0};   // reset truncates pulse
      tbl[13] = '{0, 0, 17, 0, 0};   // re-debounce after reset
      tbl[14] = '{0, 0,  2, 1, 1};   // new pulse f+18
      tbl[15] = '{0, 0,  4, 0, 1};   // held afterwards

      rst1 = 1'b1; btn1 = 1'b1; rst2 = 1'b1; btn2 = 1'b1;

      for (int i = 0; i < 16; i++) begin
         rst1 = tbl[i].rst;
         btn1 = tbl[i].btn;
         repeat (tbl[i].cyc) tick();
         check($sformatf("tbl%0d_req", i), req1, tbl[i].exp_req);
         check($sformatf("tbl%0d_prs", i), prs1, tbl[i].exp_prs);
      end

      btn1 = 1'b1;
      repeat (25) tick();

      // Clean press latency and width
      btn1 = 1'b0; k = edge_n + 1;
      repeat (30) tick();
      check_int("clean_rise", rise1, k + 18);
      check_int("clean_fall", fall1, k + 22);
      check_int("clean_pressed_rise", prise1, k + 18);
      btn1 = 1'b1;
      repeat (25) tick();

      // Bounce, then long hold, then clean release
      p0 = pulses1;
      for (int i = 0; i < 12; i++) begin
         btn1 = (i % 2 == 0) ? 1'b0 : 1'b1;
         repeat (5) tick();
      end
      btn1 = 1'b0; t = edge_n + 1;
      repeat (40) tick();
      check_int("bounce_pulses", pulses1 - p0, 1);
      check_int("bounce_rise", rise1, t + 18);
      repeat (960) tick();
      btn1 = 1'b1; r = edge_n + 1;
      repeat (25) tick();
      check_int("hold_pulses", pulses1 - p0, 1);
      check_int("hold_pressed_fall", pfall1, r + 18);
      check_int("hold_idle", int'(dut.state_q), int'(IDLE));

      // Release bounce
      btn1 = 1'b0;
      repeat (30) tick();
      p0 = pulses1;
      btn1 = 1'b1; repeat (8) tick();
      btn1 = 1'b0; repeat (3) tick();
      btn1 = 1'b1; b = edge_n + 1; pfall1 = -1;
      repeat (17) tick();
      check("relb_still_pressed", prs1, 1'b1);
      repeat (5) tick();
      check_int("relb_pressed_fall", pfall1, b + 18);
      check_int("relb_no_second_pulse", pulses1 - p0, 0);

      // Reset on the second pulse cycle, button still held
      btn1 = 1'b0; k = edge_n + 1;
      repeat (19) tick();
      check("rmp_pulse_on", req1, 1'b1);
      rst1 = 1'b1;
      tick();
      check("rmp_truncated", req1, 1'b0);
      check("rmp_pressed_clr", prs1, 1'b0);
      rst1 = 1'b0; f = edge_n + 1;
      repeat (20) tick();
      check_int("rmp_new_rise", rise1, f + 18);
      btn1 = 1'b1;
      repeat (25) tick();

      // Parameter corner D=2 P=1
      rst2 = 1'b0;
      repeat (3) tick();
      p0 = pulses2;
      btn2 = 1'b0; k = edge_n + 1;
      repeat (6) tick();
      check_int("d2_rise", rise2, k + 4);
      check_int("d2_fall", fall2, k + 5);
      check_int("d2_pulses", pulses2 - p0, 1);
      btn2 = 1'b1;
      repeat (6) tick();

      // Randomized bursts on both instances against the model
      seg1 = 0; seg2 = 0;
      for (int c = 0; c < 4000; c++) begin
         if (seg1 == 0) begin
            btn1 = 1'($urandom_range(0, 1));
            seg1 = $urandom_range(1, 40);
         end
         if (seg2 == 0) begin
            btn2 = 1'($urandom_range(0, 1));
            seg2 = $urandom_range(1, 8);
         end
         rst1 = ($urandom_range(0, 299) == 0);
         rst2 = ($urandom_range(0, 299) == 0);
         tick();
         seg1--; seg2--;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
